// File: rtl/laser_pkg.sv
// Shared types and line-level constants for the dual-lane laser link receiver.
// Build option LASER_RX_PARITY_EN (see laser_rx_lane) changes the frame to 11 bits.
package laser_pkg;

    localparam int   LASER_DATA_W    = 8;
    localparam logic LASER_IDLE_LVL  = 1'b0;
    localparam logic LASER_START_LVL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/laser_rx_lane.sv
// One laser lane: 2-FF synchronizer plus oversampling frame FSM (LSB first, idle low).
// Build option LASER_RX_PARITY_EN adds an even-parity bit between d7 and stop.
//
// state  | meaning
// IDLE   | line idle, waiting for synchronised start level
// START  | confirming start bit at its middle; a low sample is a glitch
// DATA   | sampling d0..d7 mid-bit into the shift register
// PARITY | sampling the parity bit mid-bit
// STOP   | sampling stop bit; deliver byte or flag lane_err, then IDLE
module laser_rx_lane
    import laser_pkg::*;
#(
    parameter int OVERSAMPLE = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    line_in,
    output logic [LASER_DATA_W-1:0] lane_byte,
    output logic                    lane_done,
    output logic                    lane_err
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(LASER_DATA_W);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(LASER_DATA_W - 1);

    logic                    sync1_q, sync2_q;
    rx_state_t               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [LASER_DATA_W-1:0] shreg_q, shreg_d;
    logic [LASER_DATA_W-1:0] byte_q, byte_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    stop_ok;
`ifdef LASER_RX_PARITY_EN
    logic                    par_q, par_d;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= LASER_IDLE_LVL;
            sync2_q <= LASER_IDLE_LVL;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            byte_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef LASER_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            sync1_q <= line_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            byte_q  <= byte_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef LASER_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Even parity: the parity bit equals the XOR of the eight data bits.
`ifdef LASER_RX_PARITY_EN
    assign stop_ok = (sync2_q == LASER_IDLE_LVL) && (par_q == ^shreg_q);
`else
    assign stop_ok = (sync2_q == LASER_IDLE_LVL);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        byte_d  = byte_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef LASER_RX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sync2_q == LASER_START_LVL) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = (sync2_q == LASER_START_LVL) ? DATA : IDLE;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shreg_d = {sync2_q, shreg_q[LASER_DATA_W-1:1]};
                    if (bit_q == BIT_LAST) begin
`ifdef LASER_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef LASER_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    par_d   = sync2_q;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (stop_ok) begin
                        done_d = 1'b1;
                        byte_d = shreg_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign lane_byte = byte_q;
    assign lane_done = done_q;
    assign lane_err  = err_q;

endmodule

// File: rtl/laser_link_receiver.sv
// Dual-lane laser link receiver top: two lane decoders, byte pairing with skew timeout.
// Build option LASER_RX_PARITY_EN is honoured by laser_rx_lane (11-bit frames with parity).
module laser_link_receiver
    import laser_pkg::*;
#(
    parameter int OVERSAMPLE = 8,
    parameter int SKEW_MAX   = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    laser1_in,
    input  logic                    laser2_in,
    output logic [LASER_DATA_W-1:0] data1_in,
    output logic [LASER_DATA_W-1:0] data2_in,
    output logic                    data_valid,
    output logic                    frame_error,
    output logic                    skew_error
);

    localparam int SK_W = $clog2(SKEW_MAX + 1);

    logic [LASER_DATA_W-1:0] lane1_byte, lane2_byte;
    logic                    lane1_done, lane2_done, lane1_err, lane2_err;

    logic                    f1_q, f1_d, f2_q, f2_d;
    logic [LASER_DATA_W-1:0] b1_q, b1_d, b2_q, b2_d;
    logic [LASER_DATA_W-1:0] d1_q, d1_d, d2_q, d2_d;
    logic [SK_W-1:0]         skew_q, skew_d;
    logic                    valid_q, valid_d, serr_q, serr_d, ferr_q;
    logic                    f1_set, f2_set, dup;

    laser_rx_lane #(.OVERSAMPLE(OVERSAMPLE)) u_lane1 (
        .clock     (clock),
        .reset     (reset),
        .line_in   (laser1_in),
        .lane_byte (lane1_byte),
        .lane_done (lane1_done),
        .lane_err  (lane1_err)
    );

    laser_rx_lane #(.OVERSAMPLE(OVERSAMPLE)) u_lane2 (
        .clock     (clock),
        .reset     (reset),
        .line_in   (laser2_in),
        .lane_byte (lane2_byte),
        .lane_done (lane2_done),
        .lane_err  (lane2_err)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            f1_q    <= 1'b0;
            f2_q    <= 1'b0;
            b1_q    <= '0;
            b2_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            skew_q  <= '0;
            valid_q <= 1'b0;
            serr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            f1_q    <= f1_d;
            f2_q    <= f2_d;
            b1_q    <= b1_d;
            b2_q    <= b2_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            skew_q  <= skew_d;
            valid_q <= valid_d;
            serr_q  <= serr_d;
            ferr_q  <= lane1_err | lane2_err;
        end
    end

    assign f1_set = f1_q | lane1_done;
    assign f2_set = f2_q | lane2_done;
    assign dup    = (f1_q & lane1_done) | (f2_q & lane2_done);

    // Pairing wins over the timeout, so a lane finishing on the last skew cycle still pairs.
    always_comb begin
        b1_d    = lane1_done ? lane1_byte : b1_q;
        b2_d    = lane2_done ? lane2_byte : b2_q;
        f1_d    = f1_set;
        f2_d    = f2_set;
        d1_d    = d1_q;
        d2_d    = d2_q;
        skew_d  = skew_q;
        valid_d = 1'b0;
        serr_d  = 1'b0;
        if (f1_set && f2_set) begin
            d1_d    = b1_d;
            d2_d    = b2_d;
            valid_d = 1'b1;
            serr_d  = dup;
            f1_d    = 1'b0;
            f2_d    = 1'b0;
            skew_d  = '0;
        end else if (dup) begin
            serr_d = 1'b1;
            skew_d = '0;
        end else if (lane1_done || lane2_done) begin
            skew_d = '0;
        end else if (f1_q ^ f2_q) begin
            if (skew_q == SK_W'(SKEW_MAX - 1)) begin
                f1_d   = 1'b0;
                f2_d   = 1'b0;
                serr_d = 1'b1;
                skew_d = '0;
            end else begin
                skew_d = skew_q + 1'b1;
            end
        end
    end

    assign data1_in    = d1_q;
    assign data2_in    = d2_q;
    assign data_valid  = valid_q;
    assign frame_error = ferr_q;
    assign skew_error  = serr_q;

endmodule

// File: tb/tb_laser_link_receiver.sv
// Directed bench for laser_link_receiver; define LASER_RX_PARITY_EN to match a parity build.
module tb_laser_link_receiver;

    localparam int OS   = 8;
    localparam int SKEW = 64;
`ifdef LASER_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * OS;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       laser1 = 1'b0;
    logic       laser2 = 1'b0;
    logic [7:0] data1, data2;
    logic       data_valid, frame_error, skew_error;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int vcnt = 0, fcnt = 0, scnt = 0;
    int vcyc = -1, fcyc = -1, scyc = -1;
    logic [7:0] cap1[$];
    logic [7:0] cap2[$];

    laser_link_receiver #(.OVERSAMPLE(OS), .SKEW_MAX(SKEW)) dut (
        .clock       (clock),
        .reset       (reset),
        .laser1_in   (laser1),
        .laser2_in   (laser2),
        .data1_in    (data1),
        .data2_in    (data2),
        .data_valid  (data_valid),
        .frame_error (frame_error),
        .skew_error  (skew_error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (data_valid === 1'b1) begin
            vcnt++;
            vcyc = cyc;
            cap1.push_back(data1);
            cap2.push_back(data2);
        end
        if (frame_error === 1'b1) begin
            fcnt++;
            fcyc = cyc;
        end
        if (skew_error === 1'b1) begin
            scnt++;
            scyc = cyc;
        end
    end

    task automatic drive_line(input int lane, input logic v);
        if (lane == 1) laser1 = v;
        else           laser2 = v;
    endtask

    task automatic send_lane(input int lane, input int dly, input logic [7:0] b,
                             input logic bad_stop, input logic bad_par);
        logic [FRAME_BITS-1:0] bits;
        repeat (dly) @(negedge clock);
        bits    = '0;
        bits[0] = 1'b1;
        bits[8:1] = b;
`ifdef LASER_RX_PARITY_EN
        bits[9] = (^b) ^ bad_par;
`endif
        bits[FRAME_BITS-1] = bad_stop;
        for (int i = 0; i < FRAME_BITS; i++) begin
            drive_line(lane, bits[i]);
            repeat (OS) @(negedge clock);
        end
        drive_line(lane, 1'b0);
    endtask

    task automatic send_pair(input logic [7:0] b1, input logic [7:0] b2, input int d1,
                             input int d2, input logic bs1, input logic bp1, output int t0);
        t0 = cyc;
        fork
            send_lane(1, d1, b1, bs1, bp1);
            send_lane(2, d2, b2, 1'b0, 1'b0);
        join
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge clock);
        tests++; if (data1 !== 8'h00) begin fails++; $display("FAIL reset_data1 got %h exp 00", data1); end
        tests++; if (data2 !== 8'h00) begin fails++; $display("FAIL reset_data2 got %h exp 00", data2); end
        tests++; if ({data_valid, frame_error, skew_error} !== 3'b000) begin
            fails++; $display("FAIL reset_pulses got %b exp 000", {data_valid, frame_error, skew_error});
        end
        reset = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_clean_pair();
        int t0, v0, f0, s0;
        v0 = vcnt; f0 = fcnt; s0 = scnt;
        send_pair(8'h12, 8'h34, 0, 0, 1'b0, 1'b0, t0);
        repeat (4) @(negedge clock);
        tests++; if (vcnt - v0 !== 1) begin fails++; $display("FAIL clean_valid_count got %0d exp 1", vcnt - v0); end
        tests++; if (vcyc !== t0 + FRAME_CYC) begin fails++; $display("FAIL clean_latency got %0d exp %0d", vcyc, t0 + FRAME_CYC); end
        tests++; if (data1 !== 8'h12) begin fails++; $display("FAIL clean_data1 got %h exp 12", data1); end
        tests++; if (data2 !== 8'h34) begin fails++; $display("FAIL clean_data2 got %h exp 34", data2); end
        tests++; if ((fcnt - f0) + (scnt - s0) !== 0) begin
            fails++; $display("FAIL clean_errors got %0d exp 0", (fcnt - f0) + (scnt - s0));
        end
    endtask

    task automatic test_skew();
        int t0, v0, s0;
        v0 = vcnt; s0 = scnt;
        send_pair(8'h77, 8'hc8, 0, 30, 1'b0, 1'b0, t0);
        repeat (4) @(negedge clock);
        tests++; if (vcnt - v0 !== 1) begin fails++; $display("FAIL skew30_valid_count got %0d exp 1", vcnt - v0); end
        tests++; if (vcyc !== t0 + 30 + FRAME_CYC) begin fails++; $display("FAIL skew30_latency got %0d exp %0d", vcyc, t0 + 30 + FRAME_CYC); end
        tests++; if ({data1, data2} !== 16'h77c8) begin fails++; $display("FAIL skew30_data got %h exp 77c8", {data1, data2}); end
        tests++; if (scnt - s0 !== 0) begin fails++; $display("FAIL skew30_skew_err got %0d exp 0", scnt - s0); end

        v0 = vcnt; s0 = scnt;
        send_pair(8'h21, 8'h43, 0, 100, 1'b0, 1'b0, t0);
        repeat (100) @(negedge clock);
        tests++; if (scnt - s0 !== 2) begin fails++; $display("FAIL skew100_skew_err_count got %0d exp 2", scnt - s0); end
        tests++; if (scyc !== t0 + 100 + FRAME_CYC + SKEW) begin
            fails++; $display("FAIL skew100_timeout_cycle got %0d exp %0d", scyc, t0 + 100 + FRAME_CYC + SKEW);
        end
        tests++; if (vcnt - v0 !== 0) begin fails++; $display("FAIL skew100_valid_count got %0d exp 0", vcnt - v0); end
        tests++; if ({data1, data2} !== 16'h77c8) begin fails++; $display("FAIL skew100_data_held got %h exp 77c8", {data1, data2}); end
    endtask

    task automatic test_glitch();
        int t0, v0, f0;
        v0 = vcnt; f0 = fcnt;
        laser1 = 1'b1;
        repeat (2) @(negedge clock);
        laser1 = 1'b0;
        repeat (20) @(negedge clock);
        send_pair(8'h55, 8'h55, 0, 0, 1'b0, 1'b0, t0);
        repeat (4) @(negedge clock);
        tests++; if (fcnt - f0 !== 0) begin fails++; $display("FAIL glitch_frame_err got %0d exp 0", fcnt - f0); end
        tests++; if (vcnt - v0 !== 1) begin fails++; $display("FAIL glitch_valid_count got %0d exp 1", vcnt - v0); end
        tests++; if ({data1, data2} !== 16'h5555) begin fails++; $display("FAIL glitch_data got %h exp 5555", {data1, data2}); end
    endtask

    task automatic test_bad_stop();
        int t0, v0, f0, s0;
        v0 = vcnt; f0 = fcnt; s0 = scnt;
        send_pair(8'ha5, 8'h5a, 0, 0, 1'b1, 1'b0, t0);
        repeat (100) @(negedge clock);
        tests++; if (fcnt - f0 !== 1) begin fails++; $display("FAIL badstop_frame_err_count got %0d exp 1", fcnt - f0); end
        tests++; if (fcyc !== t0 + FRAME_CYC) begin fails++; $display("FAIL badstop_frame_err_cycle got %0d exp %0d", fcyc, t0 + FRAME_CYC); end
        tests++; if (vcnt - v0 !== 0) begin fails++; $display("FAIL badstop_valid_count got %0d exp 0", vcnt - v0); end
        tests++; if (scnt - s0 !== 1) begin fails++; $display("FAIL badstop_skew_err_count got %0d exp 1", scnt - s0); end
        tests++; if (scyc !== t0 + FRAME_CYC + SKEW) begin
            fails++; $display("FAIL badstop_skew_err_cycle got %0d exp %0d", scyc, t0 + FRAME_CYC + SKEW);
        end
        tests++; if ({data1, data2} !== 16'h5555) begin fails++; $display("FAIL badstop_data_held got %h exp 5555", {data1, data2}); end
    endtask

    task automatic test_back_to_back();
        int t0, v0;
        logic [7:0] exp1 [3];
        logic [7:0] exp2 [3];
        exp1[0] = 8'h01; exp1[1] = 8'h03; exp1[2] = 8'hff;
        exp2[0] = 8'h02; exp2[1] = 8'h04; exp2[2] = 8'h00;
        cap1.delete();
        cap2.delete();
        v0 = vcnt;
        t0 = cyc;
        fork
            for (int i = 0; i < 3; i++) send_lane(1, 0, exp1[i], 1'b0, 1'b0);
            for (int j = 0; j < 3; j++) send_lane(2, 0, exp2[j], 1'b0, 1'b0);
        join
        repeat (4) @(negedge clock);
        tests++; if (vcnt - v0 !== 3) begin fails++; $display("FAIL b2b_valid_count got %0d exp 3", vcnt - v0); end
        tests++; if (vcyc !== t0 + 3 * FRAME_CYC) begin fails++; $display("FAIL b2b_last_cycle got %0d exp %0d", vcyc, t0 + 3 * FRAME_CYC); end
        for (int k = 0; k < 3; k++) begin
            if (k < cap1.size()) begin
                tests++;
                if ({cap1[k], cap2[k]} !== {exp1[k], exp2[k]}) begin
                    fails++; $display("FAIL b2b_pair%0d got %h exp %h", k, {cap1[k], cap2[k]}, {exp1[k], exp2[k]});
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int t0, v0, f0, s0;
        v0 = vcnt; f0 = fcnt; s0 = scnt;
        fork
            send_pair(8'h0f, 8'h0f, 0, 0, 1'b0, 1'b0, t0);
            begin
                repeat (43) @(negedge clock);
                reset = 1'b1;
                repeat (3) @(negedge clock);
                reset = 1'b0;
                tests++; if ({data1, data2} !== 16'h0000) begin
                    fails++; $display("FAIL midreset_data got %h exp 0000", {data1, data2});
                end
            end
        join
        repeat (100) @(negedge clock);
        tests++; if ((vcnt - v0) + (fcnt - f0) + (scnt - s0) !== 0) begin
            fails++; $display("FAIL midreset_pulses got %0d exp 0", (vcnt - v0) + (fcnt - f0) + (scnt - s0));
        end
        v0 = vcnt;
        send_pair(8'h9c, 8'h3e, 0, 0, 1'b0, 1'b0, t0);
        repeat (4) @(negedge clock);
        tests++; if (vcnt - v0 !== 1) begin fails++; $display("FAIL midreset_next_valid got %0d exp 1", vcnt - v0); end
        tests++; if ({data1, data2} !== 16'h9c3e) begin fails++; $display("FAIL midreset_next_data got %h exp 9c3e", {data1, data2}); end
    endtask

`ifdef LASER_RX_PARITY_EN
    task automatic test_parity();
        int t0, v0, f0;
        v0 = vcnt; f0 = fcnt;
        send_pair(8'h3c, 8'h3c, 0, 0, 1'b0, 1'b1, t0);
        repeat (100) @(negedge clock);
        tests++; if (fcnt - f0 !== 1) begin fails++; $display("FAIL parity_frame_err got %0d exp 1", fcnt - f0); end
        tests++; if (vcnt - v0 !== 0) begin fails++; $display("FAIL parity_valid_count got %0d exp 0", vcnt - v0); end
        tests++; if ({data1, data2} !== 16'h9c3e) begin fails++; $display("FAIL parity_data_held got %h exp 9c3e", {data1, data2}); end
    endtask
`endif

    initial begin
        @(negedge clock);
        test_reset();
        test_clean_pair();
        test_skew();
        test_glitch();
        test_bad_stop();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef LASER_RX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
